ccx_mem_rsp: RTL

- Responder end of the core memory bus: a word-addressed, memory-backed target that accepts requests from a CCX interconnect arbiter output (ROM, RAM or EXT) and returns read data or write acknowledgements.
- Instantiated once per on-chip memory region (ROM with READ_ONLY=1, RAM with READ_ONLY=0).
- Owns request acceptance, address range checking, byte-strobed storage, and the held-response handshake.

---
 rtl/ccx_pkg.sv | 29 ++
 rtl/ccx_mem_array.sv | 35 +++
 rtl/ccx_mem_rsp.sv | 132 +++++++++++++
 3 files changed

// File: rtl/ccx_pkg.sv
// Shared definitions for the CCX memory responder: state encoding, address helpers
// and the wait-counter limit.
package ccx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RSP  = 2'd2
  } ccx_state_t;

  localparam int unsigned CCX_MAX_WAIT = 15;

  // Word offset of addr inside the region; the caller truncates to its index width.
  function automatic logic [63:0] word_index(input logic [63:0] addr, input logic [63:0] base,
                                             input int unsigned dw, input logic [63:0] size);
    logic [63:0] off;
    off = addr - base;
    return (off >> $clog2(dw / 8)) & ((size / 64'(dw / 8)) - 64'd1);
  endfunction

  // Region limit is formed one bit wider so BASE+SIZE can never wrap.
  function automatic logic in_range(input logic [63:0] addr, input logic [63:0] base,
                                    input logic [63:0] size);
    logic [64:0] lim;
    lim = {1'b0, base} + {1'b0, size};
    return (addr >= base) && ({1'b0, addr} < lim);
  endfunction

endpackage

// File: rtl/ccx_mem_array.sv
// Byte-strobed single-port synchronous storage behind the CCX responder.
// Kept separate so it can be swapped for a foundry RAM macro.
module ccx_mem_array #(
  parameter int unsigned DW    = 64,
  parameter int unsigned Depth = 8192,
  parameter int unsigned IW    = 13
) (
  input  logic            clk_i,
  input  logic            cen_i,
  input  logic            wen_i,
  input  logic [DW/8-1:0] strb_i,
  input  logic [IW-1:0]   idx_i,
  input  logic [DW-1:0]   wdata_i,
  output logic [DW-1:0]   rdata_o
);

  logic [DW-1:0] mem_q [Depth];
  logic [DW-1:0] rdata_q;

  // Strobed write or registered read on each enabled cycle; contents have no reset.
  always_ff @(posedge clk_i) begin
    if (cen_i) begin
      if (wen_i) begin
        for (int unsigned i = 0; i < DW / 8; i++) begin
          if (strb_i[i]) mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end else begin
        rdata_q <= mem_q[idx_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ccx_mem_rsp.sv
// CCX memory responder: accepts word-addressed requests, range-checks them, updates
// or reads byte-strobed storage and holds the response until acknowledged.
// Optional extra latency is enabled with the CCX_MEM_RSP_WAIT_EN macro.
module ccx_mem_rsp
  import ccx_pkg::*;
#(
  parameter int unsigned AW          = 39,
  parameter int unsigned DW          = 64,
  parameter logic [63:0] BASE        = 64'h0001_0000,
  parameter logic [63:0] SIZE        = 64'h0001_0000,
  parameter bit          READ_ONLY   = 1'b0,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic            g_clk,
  input  logic            g_resetn,
  input  logic            req,
  output logic            gnt,
  input  logic            wen,
  input  logic [DW/8-1:0] strb,
  input  logic [AW-1:0]   addr,
  input  logic [DW-1:0]   wdata,
  output logic            recv,
  input  logic            ack,
  output logic [DW-1:0]   rdata,
  output logic            error
);

  localparam int unsigned Words = 32'(SIZE / 64'(DW / 8));
  localparam int unsigned IW    = (Words > 1) ? $clog2(Words) : 1;

  localparam logic [1:0] StIdle = IDLE;
  localparam logic [1:0] StRsp  = RSP;
`ifdef CCX_MEM_RSP_WAIT_EN
  localparam logic [1:0] StWait   = WAIT;
  localparam logic [3:0] WaitLoad = 4'(WAIT_CYCLES);
`endif

  if (WAIT_CYCLES > CCX_MAX_WAIT) begin : g_bad_wait
    $error("WAIT_CYCLES out of range");
  end

  logic [1:0]    state_q, state_d;
  logic          err_q, zero_q;
  logic          accept, req_err, mem_wen;
  logic [IW-1:0] idx;
  logic [DW-1:0] arr_rdata;
  logic [1:0]    acc_state;
`ifdef CCX_MEM_RSP_WAIT_EN
  logic [3:0]    cnt_q, cnt_d;
`endif

  assign gnt     = (state_q == StIdle) || ((state_q == StRsp) && ack);
  assign accept  = req && gnt;
  assign req_err = !in_range(64'(addr), BASE, SIZE) || (wen && READ_ONLY);
  assign mem_wen = wen && !req_err;
  assign idx     = IW'(word_index(64'(addr), BASE, DW, SIZE));

`ifdef CCX_MEM_RSP_WAIT_EN
  assign acc_state = (WaitLoad != 4'd0) ? StWait : StRsp;
`else
  assign acc_state = StRsp;
`endif

  // Next-state: accept from IDLE or from RSP on ack, count down through WAIT.
  always_comb begin
    state_d = state_q;
`ifdef CCX_MEM_RSP_WAIT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      StIdle: begin
        if (accept) state_d = acc_state;
      end
      StRsp: begin
        if (ack) state_d = accept ? acc_state : StIdle;
      end
`ifdef CCX_MEM_RSP_WAIT_EN
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = StRsp;
      end
`endif
      default: state_d = StIdle;
    endcase
`ifdef CCX_MEM_RSP_WAIT_EN
    if (accept) cnt_d = WaitLoad;
`endif
  end

  // State and response-attribute registers; attributes latch at each accept.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q <= StIdle;
      err_q   <= 1'b0;
      zero_q  <= 1'b1;
`ifdef CCX_MEM_RSP_WAIT_EN
      cnt_q   <= 4'd0;
`endif
    end else begin
      state_q <= state_d;
`ifdef CCX_MEM_RSP_WAIT_EN
      cnt_q   <= cnt_d;
`endif
      if (accept) begin
        err_q  <= req_err;
        zero_q <= req_err || wen;
      end
    end
  end

  ccx_mem_array #(
    .DW    (DW),
    .Depth (Words),
    .IW    (IW)
  ) u_array (
    .clk_i   (g_clk),
    .cen_i   (accept),
    .wen_i   (mem_wen),
    .strb_i  (strb),
    .idx_i   (idx),
    .wdata_i (wdata),
    .rdata_o (arr_rdata)
  );

  // Writes and errors return zero data; nothing is driven outside RSP.
  always_comb begin
    recv  = (state_q == StRsp);
    error = recv && err_q;
    rdata = (recv && !zero_q) ? arr_rdata : '0;
  end

endmodule
